// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared types and constants for the datapath sequencing controller
//
// Purpose: state encoding, default inter-word timeout and counter widths
//          shared by datapath_ctrl and ctrl_timer.
// Ports:   none (package).
package datapath_ctrl_pkg;

   localparam int TIMEOUT_DEF = 15;   // idle cycles allowed between words of one group
   localparam int CNT_W       = 8;    // group_cnt / abort_cnt width
   localparam int TMR_W       = 8;    // inter-word timer width

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_C    = 3'd2,
      S_D    = 3'd3,
      S_SUM  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // States in which an operand word may be accepted.
   function automatic logic is_operand_state(input state_t s);
      return (s == S_A) || (s == S_B) || (s == S_C) || (s == S_D);
   endfunction

   // States in which a group is partially captured and the timer runs.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_B) || (s == S_C) || (s == S_D);
   endfunction

endpackage

// File: rtl/ctrl_timer.sv
// rtl/ctrl_timer.sv - inter-word idle timer with clear/count/compare
//
// Purpose: counts idle cycles between operand words; expire flags the
//          cycle in which the count would reach TIMEOUT.
// Ports:
//   clock   in  1  rising-edge clock
//   rst     in  1  synchronous active-high reset
//   clear   in  1  zero the count on this edge (wins over count)
//   count   in  1  advance the count on this edge
//   expire  out 1  count is asserted and this cycle brings the count to TIMEOUT
module ctrl_timer
   import datapath_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clock,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expire
);

   logic [TMR_W-1:0] cnt;

   // Combinational so the abort takes effect in the same cycle the limit is
   // hit; a transfer that cycle deasserts count and so suppresses expire.
   assign expire = count && (cnt == TMR_W'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - sequencing controller for the (A+B)-(C+D) datapath
//
// Purpose: accepts a valid/ready stream of four operand words on the shared
//          din bus (not routed through here), issues capture strobes A..D,
//          then pulses en to load the result and done to flag completion.
//          Aborts a partial group after TIMEOUT idle cycles.
// Ports:
//   clock      in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   valid      in  1  source presents an operand word this cycle
//   ready      out 1  word accepted this cycle when valid is also high
//   A,B,C,D    out 1  per-operand capture strobes (one-hot or idle)
//   en         out 1  result register load strobe
//   done       out 1  one-cycle completion pulse, result stable
//   err        out 1  one-cycle abort pulse on timeout
//   group_cnt  out 8  completed groups, wrapping
//   abort_cnt  out 8  aborted groups, saturating
module datapath_ctrl
   import datapath_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             valid,
   output logic             ready,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             en,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] group_cnt,
   output logic [CNT_W-1:0] abort_cnt
);

   state_t state;
   logic   xfer;
   logic   in_wait;
   logic   expire;

   // ready is masked by rst so nothing transfers during the reset cycle.
   assign ready   = !rst && is_operand_state(state);
   assign xfer    = valid && ready;
   assign in_wait = is_wait_state(state);

   assign A = xfer && (state == S_A);
   assign B = xfer && (state == S_B);
   assign C = xfer && (state == S_C);
   assign D = xfer && (state == S_D);

   // Reset drops a group silently, so no err while rst is high.
   assign err = expire && !rst;

   ctrl_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock  (clock),
      .rst    (rst),
      .clear  (xfer || !in_wait),
      .count  (in_wait && !xfer),
      .expire (expire)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= S_A;
         en        <= 1'b0;
         done      <= 1'b0;
         group_cnt <= '0;
         abort_cnt <= '0;
      end else begin
         en   <= 1'b0;
         done <= 1'b0;
         case (state)
            S_A: begin
               if (xfer) state <= S_B;
            end
            S_B: begin
               if (xfer)        state <= S_C;
               else if (expire) state <= S_A;
            end
            S_C: begin
               if (xfer)        state <= S_D;
               else if (expire) state <= S_A;
            end
            S_D: begin
               if (xfer) begin
                  state <= S_SUM;
                  en    <= 1'b1;
               end else if (expire) begin
                  state <= S_A;
               end
            end
            S_SUM: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               state     <= S_A;
               group_cnt <= group_cnt + 1'b1;
            end
            default: begin
               state <= S_A;
            end
         endcase

         if (expire && (abort_cnt != {CNT_W{1'b1}})) begin
            abort_cnt <= abort_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

   logic       clock = 1'b0;
   logic       rst;
   logic       valid;
   logic [3:0] din;
   logic       ready, A, B, C, D, en, done, err;
   logic [7:0] group_cnt, abort_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clock = ~clock;

   datapath_ctrl #(
      .TIMEOUT (4)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .valid     (valid),
      .ready     (ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .en        (en),
      .done      (done),
      .err       (err),
      .group_cnt (group_cnt),
      .abort_cnt (abort_cnt)
   );

   // Datapath: captures din on the strobe edge, registers the 5-bit result on en.
   logic [3:0] ra, rb, rc, rd;
   logic [4:0] result;
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (A) ra <= din;
      if (B) rb <= din;
      if (C) rc <= din;
      if (D) rd <= din;
      if (en) result <= ({1'b0, ra} + {1'b0, rb}) - ({1'b0, rc} + {1'b0, rd});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic [3:0] w, input logic [3:0] exp_strobe);
      int n = 0;
      @(negedge clock);
      valid = 1'b1;
      din   = w;
      #1;
      while (!ready && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("ready", ready, 1);
      check("strobe", {A, B, C, D}, exp_strobe);
      check("err_xfer", err, 0);
   endtask

   task automatic finish_group(input logic keep, input logic [4:0] exp);
      @(negedge clock);
      valid = keep;
      #1;
      check("en", en, 1);
      check("ready_sum", ready, 0);
      check("strobe_sum", {A, B, C, D}, 0);
      @(negedge clock);
      #1;
      check("done", done, 1);
      check("en_done", en, 0);
      check("ready_done", ready, 0);
      check("strobe_done", {A, B, C, D}, 0);
      check("result", result, exp);
   endtask

   task automatic send_group(input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3,
                             input logic keep, input logic [4:0] exp);
      xfer(w0, 4'b1000);
      xfer(w1, 4'b0100);
      xfer(w2, 4'b0010);
      xfer(w3, 4'b0001);
      finish_group(keep, exp);
   endtask

   task automatic idle(input logic exp_err);
      @(negedge clock);
      valid = 1'b0;
      #1;
      check("err_idle", err, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] gb;
      logic [3:0] w0, w1, w2, w3;
      logic [4:0] e;
      int c0;

      rst   = 1'b1;
      valid = 1'b0;
      din   = 4'd0;
      #1;
      check("ready_in_rst", ready, 0);
      @(negedge clock);
      rst = 1'b0;
      #1;
      check("rst_ready", ready, 1);
      check("rst_strobes", {A, B, C, D}, 0);
      check("rst_en", en, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_gcnt", group_cnt, 0);
      check("rst_acnt", abort_cnt, 0);

      // Basic groups, including modulo-32 wrap of the difference.
      send_group(4'd3, 4'd5, 4'd2, 4'd1, 1'b1, 5'd5);
      idle(1'b0);
      check("gcnt_1", group_cnt, 1);
      send_group(4'd1, 4'd1, 4'd9, 4'd9, 1'b0, 5'd16);
      send_group(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 5'd0);
      idle(1'b0);
      check("gcnt_3", group_cnt, 3);

      // Timeout after A,B then four idle cycles.
      xfer(4'd2, 4'b1000);
      xfer(4'd3, 4'b0100);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);
      check("acnt_1", abort_cnt, 1);
      check("gcnt_abort", group_cnt, 3);
      send_group(4'd4, 4'd4, 4'd1, 4'd1, 1'b0, 5'd6);

      // Transfer on the limit cycle wins over the abort.
      xfer(4'd7, 4'b1000);
      xfer(4'd7, 4'b0100);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      xfer(4'd1, 4'b0010);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      xfer(4'd1, 4'b0001);
      finish_group(1'b0, 5'd12);
      idle(1'b0);
      check("acnt_win", abort_cnt, 1);
      check("gcnt_win", group_cnt, 5);

      // Reset while in S_C drops the group silently.
      xfer(4'd5, 4'b1000);
      xfer(4'd5, 4'b0100);
      @(negedge clock);
      rst   = 1'b1;
      valid = 1'b1;
      din   = 4'd9;
      #1;
      check("midrst_ready", ready, 0);
      check("midrst_strobe", {A, B, C, D}, 0);
      check("midrst_err", err, 0);
      @(negedge clock);
      rst   = 1'b0;
      valid = 1'b0;
      #1;
      check("postrst_ready", ready, 1);
      check("postrst_err", err, 0);
      check("postrst_en", en, 0);
      check("postrst_done", done, 0);
      check("postrst_gcnt", group_cnt, 0);
      check("postrst_acnt", abort_cnt, 0);
      send_group(4'd6, 4'd7, 4'd2, 4'd3, 1'b0, 5'd8);

      // 256 back-to-back groups with valid held high: wrap and throughput.
      @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      #1;
      c0 = cyc;
      for (int g = 0; g < 256; g++) begin
         gb = g[7:0];
         w0 = gb[3:0];
         w1 = gb[7:4];
         w2 = ~gb[3:0];
         w3 = gb[5:2];
         e  = ({1'b0, w0} + {1'b0, w1}) - ({1'b0, w2} + {1'b0, w3});
         send_group(w0, w1, w2, w3, 1'b1, e);
         check("gcnt_loop", group_cnt, gb);
      end
      check("cycles_256", cyc - c0, 1536);
      idle(1'b0);
      check("gcnt_wrap", group_cnt, 0);
      check("acnt_end", abort_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
